decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 140 ++++++++++++++
 tb/tb_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: field extraction, register scoreboard with writeback forwarding,
// and a one-entry output register toward execute.
//
// state  | meaning
// RUN    | instructions accepted whenever operands and output slot allow
// HALTED | halt decoded; no further accepts, output register still drains
module decode_stage #(
   parameter logic [4:0] RNONE = 5'd31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_icode,
   input  logic [4:0] in_rA,
   input  logic [4:0] in_rB,
   output logic [4:0] readReg1,
   output logic [4:0] readReg2,
   input  logic [7:0] valueRead1,
   input  logic [7:0] valueRead2,
   input  logic       wb_write1,
   input  logic [4:0] wb_reg1,
   input  logic [7:0] wb_val1,
   input  logic       wb_write2,
   input  logic [4:0] wb_reg2,
   input  logic [7:0] wb_val2,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_icode,
   output logic [7:0] out_valA,
   output logic [7:0] out_valB,
   output logic [4:0] out_dstE,
   output logic [4:0] out_dstM,
   output logic       halted
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state;
   logic [31:0] busy;
   logic [31:0] busyNext;
   logic [4:0]  srcA, srcB, dstE, dstM;
   logic        hitA1, hitA2, hitB1, hitB2;
   logic        stallA, stallB, outBlocked, accept;
   logic [7:0]  valA, valB;

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (in_icode)
         4'h2, 4'h4, 4'h6, 4'hA: srcA = in_rA;
         default: ;
      endcase
      case (in_icode)
         4'h4, 4'h5, 4'h6:       srcB = in_rB;
         4'h8, 4'h9, 4'hA, 4'hB: srcB = 5'd4;
         default: ;
      endcase
      case (in_icode)
         4'h2, 4'h3, 4'h6:       dstE = in_rB;
         4'h8, 4'h9, 4'hA, 4'hB: dstE = 5'd4;
         default: ;
      endcase
      case (in_icode)
         4'h5, 4'hB: dstM = in_rA;
         default: ;
      endcase
   end

   assign readReg1 = srcA;
   assign readReg2 = srcB;

   assign hitA1 = wb_write1 && (wb_reg1 == srcA);
   assign hitA2 = wb_write2 && (wb_reg2 == srcA);
   assign hitB1 = wb_write1 && (wb_reg1 == srcB);
   assign hitB2 = wb_write2 && (wb_reg2 == srcB);

   // Port 2 is the younger writeback, so it wins over port 1.
   assign valA = hitA2 ? wb_val2 : (hitA1 ? wb_val1 : valueRead1);
   assign valB = hitB2 ? wb_val2 : (hitB1 ? wb_val1 : valueRead2);

   assign stallA     = (srcA != RNONE) && busy[srcA] && !hitA1 && !hitA2;
   assign stallB     = (srcB != RNONE) && busy[srcB] && !hitB1 && !hitB2;
   assign outBlocked = out_valid && !out_ready;
   assign in_ready   = !reset && (state == RUN) && !stallA && !stallB && !outBlocked;
   assign accept     = in_valid && in_ready;

   // Clears first, then sets, so a new producer overrides a retiring one.
   always_comb begin
      busyNext = busy;
      if (wb_write1) busyNext[wb_reg1] = 1'b0;
      if (wb_write2) busyNext[wb_reg2] = 1'b0;
      if (accept) begin
         if (dstE != RNONE) busyNext[dstE] = 1'b1;
         if (dstM != RNONE) busyNext[dstM] = 1'b1;
      end
      busyNext[RNONE] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         halted    <= 1'b0;
         busy      <= '0;
         out_valid <= 1'b0;
         out_icode <= 4'h0;
         out_valA  <= 8'h00;
         out_valB  <= 8'h00;
         out_dstE  <= RNONE;
         out_dstM  <= RNONE;
      end else begin
         busy <= busyNext;
         if (accept) begin
            out_valid <= 1'b1;
            out_icode <= in_icode;
            out_valA  <= valA;
            out_valB  <= valB;
            out_dstE  <= dstE;
            out_dstM  <= dstM;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            RUN: begin
               if (accept && (in_icode == 4'h0)) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               halted <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_decode_stage;

   localparam logic [4:0] N = 5'd31;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_icode;
   logic [4:0] in_rA, in_rB;
   logic [4:0] readReg1, readReg2;
   logic [7:0] valueRead1, valueRead2;
   logic       wb_write1, wb_write2;
   logic [4:0] wb_reg1, wb_reg2;
   logic [7:0] wb_val1, wb_val2;
   logic       out_valid, out_ready;
   logic [3:0] out_icode;
   logic [7:0] out_valA, out_valB;
   logic [4:0] out_dstE, out_dstM;
   logic       halted;

   int checks   = 0;
   int failures = 0;

   decode_stage #(.RNONE(N)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
      .readReg1(readReg1), .readReg2(readReg2),
      .valueRead1(valueRead1), .valueRead2(valueRead2),
      .wb_write1(wb_write1), .wb_reg1(wb_reg1), .wb_val1(wb_val1),
      .wb_write2(wb_write2), .wb_reg2(wb_reg2), .wb_val2(wb_val2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_icode(out_icode), .out_valA(out_valA), .out_valB(out_valB),
      .out_dstE(out_dstE), .out_dstM(out_dstM),
      .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic clearIn();
      in_valid = 0; in_icode = 4'h1; in_rA = N; in_rB = N;
      valueRead1 = 8'h00; valueRead2 = 8'h00;
      wb_write1 = 0; wb_reg1 = 5'd0; wb_val1 = 8'h00;
      wb_write2 = 0; wb_reg2 = 5'd0; wb_val2 = 8'h00;
      out_ready = 1;
   endtask

   task automatic setIn(input logic [3:0] ic, input logic [4:0] a, input logic [4:0] b);
      in_valid = 1; in_icode = ic; in_rA = a; in_rB = b;
   endtask

   task automatic doReset();
      @(negedge clk);
      clearIn();
      in_valid = 1; in_icode = 4'h2; in_rA = 5'd1; in_rB = 5'd2;
      reset = 1;
      #1 chk("ready_during_reset", in_ready, 0);
      @(posedge clk); #1;
      reset = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_icode", out_icode, 0);
      chk("rst_valA", out_valA, 0);
      chk("rst_valB", out_valB, 0);
      chk("rst_dstE", out_dstE, N);
      chk("rst_dstM", out_dstM, N);
   endtask

   // Field rules written as register-usage sets per opcode.
   task automatic decodeRef(input logic [3:0] ic, input logic [4:0] a, input logic [4:0] b,
                            output logic [4:0] sA, output logic [4:0] sB,
                            output logic [4:0] dE, output logic [4:0] dM);
      sA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? a : N;
      sB = (ic inside {4'h4, 4'h5, 4'h6}) ? b : ((ic inside {[4'h8:4'hB]}) ? 5'd4 : N);
      dE = (ic inside {4'h2, 4'h3, 4'h6}) ? b : ((ic inside {[4'h8:4'hB]}) ? 5'd4 : N);
      dM = (ic inside {4'h5, 4'hB}) ? a : N;
   endtask

   typedef struct {
      logic [3:0] icode;
      logic [4:0] srcA, srcB, dstE, dstM;
   } vec_t;

   vec_t vecs[16];

   bit         mBusy[32];
   bit         mHalted, mOV;
   logic [3:0] mIcode;
   logic [7:0] mA, mB;
   logic [4:0] mE, mM;

   function automatic logic [4:0] pickReg();
      int v = $urandom_range(0, 8);
      return (v == 8) ? N : 5'(v);
   endfunction

   initial begin
      int accepts;
      reset = 0;
      clearIn();

      vecs[0]  = '{4'h0, N,    N,    N,    N};
      vecs[1]  = '{4'h1, N,    N,    N,    N};
      vecs[2]  = '{4'h2, 5'd1, N,    5'd3, N};
      vecs[3]  = '{4'h3, N,    N,    5'd3, N};
      vecs[4]  = '{4'h4, 5'd1, 5'd3, N,    N};
      vecs[5]  = '{4'h5, N,    5'd3, N,    5'd1};
      vecs[6]  = '{4'h6, 5'd1, 5'd3, 5'd3, N};
      vecs[7]  = '{4'h7, N,    N,    N,    N};
      vecs[8]  = '{4'h8, N,    5'd4, 5'd4, N};
      vecs[9]  = '{4'h9, N,    5'd4, 5'd4, N};
      vecs[10] = '{4'hA, 5'd1, 5'd4, 5'd4, N};
      vecs[11] = '{4'hB, N,    5'd4, 5'd4, 5'd1};
      for (int i = 12; i < 16; i++) vecs[i] = '{4'(i), N, N, N, N};

      for (int i = 0; i < 16; i++) begin
         doReset();
         @(negedge clk);
         setIn(vecs[i].icode, 5'd1, 5'd3);
         valueRead1 = 8'h40 + 8'(i);
         valueRead2 = 8'h80 + 8'(i);
         #1;
         chk($sformatf("tbl%0d_readReg1", i), readReg1, vecs[i].srcA);
         chk($sformatf("tbl%0d_readReg2", i), readReg2, vecs[i].srcB);
         chk($sformatf("tbl%0d_ready", i), in_ready, 1);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_icode", i), out_icode, vecs[i].icode);
         chk($sformatf("tbl%0d_valA", i), out_valA, 8'h40 + 8'(i));
         chk($sformatf("tbl%0d_valB", i), out_valB, 8'h80 + 8'(i));
         chk($sformatf("tbl%0d_dstE", i), out_dstE, vecs[i].dstE);
         chk($sformatf("tbl%0d_dstM", i), out_dstM, vecs[i].dstM);
      end

      // rrmovl, then OPl stalled on r2 until writeback forwards it
      doReset();
      @(negedge clk); setIn(4'h2, 5'd1, 5'd2); valueRead1 = 8'h5A;
      #1 chk("rrmovl_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("rrmovl_valA", out_valA, 8'h5A);
      chk("rrmovl_dstE", out_dstE, 5'd2);
      @(negedge clk); setIn(4'h6, 5'd3, 5'd2); valueRead2 = 8'hEE;
      #1 chk("opl_stall", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk); wb_write1 = 1; wb_reg1 = 5'd2; wb_val1 = 8'h33;
      #1 chk("opl_fwd_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("opl_valB", out_valB, 8'h33);
      chk("opl_icode", out_icode, 4'h6);
      @(negedge clk); clearIn(); setIn(4'h2, 5'd2, 5'd5);
      #1 chk("set_wins_stall", in_ready, 0);

      // both writeback ports hit the same source
      doReset();
      @(negedge clk); setIn(4'h2, 5'd3, 5'd6); valueRead1 = 8'h77;
      wb_write1 = 1; wb_reg1 = 5'd3; wb_val1 = 8'h11;
      wb_write2 = 1; wb_reg2 = 5'd3; wb_val2 = 8'h22;
      #1 chk("dualwb_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("dualwb_valA", out_valA, 8'h22);

      // backpressure: exactly one accept while execute is stalled
      doReset();
      accepts = 0;
      @(negedge clk); setIn(4'h7, N, N); out_ready = 0;
      #1 if (in_ready) accepts++;
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); setIn(4'hC, N, N); out_ready = 0;
         #1 if (in_ready) accepts++;
         @(posedge clk); #1;
         chk("bp_frozen_icode", out_icode, 4'h7);
         chk("bp_frozen_valid", out_valid, 1);
      end
      chk("bp_accepts", accepts, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); setIn(4'(c + 1), N, 5'd5); out_ready = 1;
         #1 chk("flow_ready", in_ready, 1);
         @(posedge clk); #1;
         chk("flow_icode", out_icode, 4'(c + 1));
      end

      // halt and recovery through reset
      doReset();
      @(negedge clk); setIn(4'h0, N, N);
      #1 chk("halt_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("halt_flag", halted, 1);
      chk("halt_delivered", out_icode, 4'h0);
      chk("halt_valid", out_valid, 1);
      @(negedge clk); setIn(4'h1, N, N);
      #1 chk("halted_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("halted_drain", out_valid, 0);
      chk("halted_stays", halted, 1);
      doReset();
      @(negedge clk); setIn(4'h2, 5'd1, 5'd2);
      #1 chk("post_halt_ready", in_ready, 1);
      @(posedge clk); #1;

      // popl: shared dstE/dstM, single busy bit freed by one writeback
      doReset();
      @(negedge clk); setIn(4'hB, 5'd4, 5'd0);
      #1 chk("popl_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("popl_dstE", out_dstE, 5'd4);
      chk("popl_dstM", out_dstM, 5'd4);
      @(negedge clk); setIn(4'h2, 5'd4, 5'd5);
      #1 chk("popl_busy", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk); in_valid = 0; wb_write1 = 1; wb_reg1 = 5'd4;
      @(posedge clk); #1;
      @(negedge clk); clearIn(); setIn(4'h2, 5'd4, 5'd5);
      #1 chk("popl_freed", in_ready, 1);
      @(posedge clk); #1;

      // randomized traffic against the model
      doReset();
      foreach (mBusy[i]) mBusy[i] = 0;
      mHalted = 0; mOV = 0; mIcode = 0; mA = 0; mB = 0; mE = N; mM = N;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [4:0] sA, sB, dE, dM;
         logic [7:0] fA, fB;
         logic stA, stB, expReady, acc;
         int v;
         @(negedge clk);
         reset = ($urandom_range(0, 79) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         v = $urandom_range(0, 15);
         if (v == 0 && $urandom_range(0, 19) != 0) v = 1;
         in_icode = 4'(v);
         in_rA = pickReg(); in_rB = pickReg();
         valueRead1 = 8'($urandom); valueRead2 = 8'($urandom);
         wb_write1 = ($urandom_range(0, 2) == 0); wb_reg1 = pickReg(); wb_val1 = 8'($urandom);
         wb_write2 = ($urandom_range(0, 2) == 0); wb_reg2 = pickReg(); wb_val2 = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         decodeRef(in_icode, in_rA, in_rB, sA, sB, dE, dM);
         fA = (wb_write2 && wb_reg2 == sA) ? wb_val2 : (wb_write1 && wb_reg1 == sA) ? wb_val1 : valueRead1;
         fB = (wb_write2 && wb_reg2 == sB) ? wb_val2 : (wb_write1 && wb_reg1 == sB) ? wb_val1 : valueRead2;
         stA = (sA != N) && mBusy[sA] && !(wb_write1 && wb_reg1 == sA) && !(wb_write2 && wb_reg2 == sA);
         stB = (sB != N) && mBusy[sB] && !(wb_write1 && wb_reg1 == sB) && !(wb_write2 && wb_reg2 == sB);
         expReady = !reset && !mHalted && !stA && !stB && !(mOV && !out_ready);
         chk("rnd_ready", in_ready, expReady);
         chk("rnd_readReg1", readReg1, sA);
         chk("rnd_readReg2", readReg2, sB);
         acc = in_valid && expReady;
         if (reset) begin
            foreach (mBusy[i]) mBusy[i] = 0;
            mHalted = 0; mOV = 0; mIcode = 0; mA = 0; mB = 0; mE = N; mM = N;
         end else begin
            if (wb_write1) mBusy[wb_reg1] = 0;
            if (wb_write2) mBusy[wb_reg2] = 0;
            if (acc) begin
               if (dE != N) mBusy[dE] = 1;
               if (dM != N) mBusy[dM] = 1;
               mOV = 1; mIcode = in_icode; mA = fA; mB = fB; mE = dE; mM = dM;
               if (in_icode == 4'h0) mHalted = 1;
            end else if (out_ready) begin
               mOV = 0;
            end
         end
         @(posedge clk); #1;
         reset = 0;
         chk("rnd_out_valid", out_valid, mOV);
         chk("rnd_halted", halted, mHalted);
         chk("rnd_icode", out_icode, mIcode);
         chk("rnd_valA", out_valA, mA);
         chk("rnd_valB", out_valB, mB);
         chk("rnd_dstE", out_dstE, mE);
         chk("rnd_dstM", out_dstM, mM);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
